// File: rtl/ei_axi4_slave_wr_mem_if.sv
// AXI4 write-channel bundle (AW, W, B) between a write master and the
// memory-backed write slave.
interface ei_axi4_slave_wr_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [NBYTES-1:0]     wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/ei_axi4_slave_wr_mem.sv
// AXI4 write-only slave backed by a byte-lane memory. Accepts one burst at a
// time (IDLE -> DATA -> RESP), supports FIXED/INCR/WRAP addressing, reports
// SLVERR for illegal bursts or wlast misplacement and DECERR for beats that
// fall outside the memory. A combinational backdoor port reads any word.
module ei_axi4_slave_wr_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    ei_axi4_slave_wr_mem_if.slave        axi,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_rdata
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int LANE_W = $clog2(NBYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  illegal_q, illegal_d;
    logic                  decerr_q, decerr_d;
    logic [1:0]            bresp_q, bresp_d;

    logic [ADDR_WIDTH-1:0] step, blk, next_addr, word_full;
    logic                  in_range, mem_we, last_cnt, slverr_now, decerr_now;
    logic [IDX_W-1:0]      wr_idx;

    // Beat address decode and next-beat address for the captured burst type.
    always_comb begin
        step      = ADDR_WIDTH'(1) << size_q;
        blk       = ADDR_WIDTH'({1'b0, len_q} + 9'd1) << size_q;
        word_full = addr_q >> LANE_W;
        in_range  = word_full < ADDR_WIDTH'(MEM_DEPTH);
        wr_idx    = word_full[IDX_W-1:0];
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~(blk - 1'b1)) | ((addr_q + step) & (blk - 1'b1));
            default: next_addr = (addr_q & ~(step - 1'b1)) + step;
        endcase
    end

    // Next-state, burst bookkeeping and write enable.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        illegal_d  = illegal_q;
        decerr_d   = decerr_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        last_cnt   = (cnt_q == len_q);
        slverr_now = illegal_q || (last_cnt != axi.wlast);
        decerr_now = decerr_q || (!illegal_q && !in_range);
        case (state_q)
            ST_IDLE: begin
                if (axi.awvalid) begin
                    addr_d    = axi.awaddr;
                    len_d     = axi.awlen;
                    size_d    = axi.awsize;
                    burst_d   = axi.awburst;
                    cnt_d     = 8'd0;
                    decerr_d  = 1'b0;
                    // Illegal bursts still consume their beats but write nothing.
                    illegal_d = (axi.awburst == 2'b11)
                             || (axi.awsize > 3'(LANE_W))
                             || ((axi.awburst == 2'b10) &&
                                 !((axi.awlen == 8'd1) || (axi.awlen == 8'd3) ||
                                   (axi.awlen == 8'd7) || (axi.awlen == 8'd15)));
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (axi.wvalid) begin
                    mem_we   = !illegal_q && in_range;
                    decerr_d = decerr_now;
                    addr_d   = next_addr;
                    cnt_d    = cnt_q + 8'd1;
                    // Either the counted last beat or an early wlast ends the burst.
                    if (last_cnt || axi.wlast) begin
                        state_d = ST_RESP;
                        bresp_d = slverr_now ? 2'b10 : (decerr_now ? 2'b11 : 2'b00);
                    end
                end
            end
            ST_RESP: begin
                if (axi.bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and burst registers; reset abandons any burst in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            decerr_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            decerr_q  <= decerr_d;
            bresp_q   <= bresp_d;
        end
    end

    assign axi.awready = (state_q == ST_IDLE);
    assign axi.wready  = (state_q == ST_DATA);
    assign axi.bvalid  = (state_q == ST_RESP);
    assign axi.bresp   = bresp_q;

    // One byte-wide memory per lane so wstrb maps directly onto lane writes.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic [7:0] mem_lane [MEM_DEPTH];

            // Lane write; contents are deliberately left uninitialised by reset.
            always_ff @(posedge aclk) begin
                if (mem_we && axi.wstrb[gi]) begin
                    mem_lane[wr_idx] <= axi.wdata[gi*8 +: 8];
                end
            end

            assign dbg_rdata[gi*8 +: 8] = mem_lane[dbg_addr];
        end
    endgenerate
endmodule

// File: doc/ei_axi4_slave_wr_mem.md
EI_AXI4_SLAVE_WR_MEM -- requirements
Module: ei_axi4_slave_wr_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of awaddr.
REQ-002 Parameter DATA_WIDTH, default 32, data width in bits (32 or 64); NBYTES = DATA_WIDTH/8.
REQ-003 Parameter MEM_DEPTH, default 256, number of DATA_WIDTH words in the backing memory.
REQ-004 aclk  in  1  single clock; all logic on rising edge.
REQ-005 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 awaddr  in  ADDR_WIDTH  burst start byte address.
REQ-007 awlen  in  8  beats minus one.
REQ-008 awsize  in  3  log2 bytes per beat.
REQ-009 awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-010 awvalid / awready  in / out  1 each  AW handshake.
REQ-011 wdata  in  DATA_WIDTH  write data.
REQ-012 wstrb  in  NBYTES  byte-lane enables.
REQ-013 wlast  in  1  last beat marker.
REQ-014 wvalid / wready  in / out  1 each  W handshake.
REQ-015 bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
REQ-016 bvalid / bready  out / in  1 each  B handshake.
REQ-017 dbg_addr  in  log2(MEM_DEPTH)  word index for backdoor read.
REQ-018 dbg_rdata  out  DATA_WIDTH  combinational mem[dbg_addr].

Function
REQ-019 States IDLE, DATA, RESP; IDLE: awready=1, wready=0, bvalid=0.
REQ-020 IDLE, awvalid&&awready: capture awaddr/awlen/awsize/awburst, clear beat counter and error flag, -> DATA next cycle.
REQ-021 DATA: awready=0, wready=1, bvalid=0; each wvalid&&wready is one beat.
REQ-022 Per beat: word index = current_addr / NBYTES; bytes with wstrb[i]=1 written to lane i; no lane masking by awsize.
REQ-023 Next address: FIXED unchanged; INCR += 2^awsize (first increment from size-aligned start); WRAP wraps within aligned block of (awlen+1)*2^awsize bytes.
REQ-024 Beat with counter==awlen -> RESP next cycle; if wlast=0 on it, SLVERR.
REQ-025 wlast=1 with counter<awlen: beat written, SLVERR, -> RESP next cycle (burst terminated).
REQ-026 SLVERR, no beats written (all accepted): awburst=11; awsize > log2(NBYTES); WRAP with awlen not in {1,3,7,15}.
REQ-027 Beat whose word index >= MEM_DEPTH: not written, DECERR recorded; SLVERR takes priority over DECERR in bresp.
REQ-028 RESP: bvalid=1, bresp stable, wready=0, awready=0; bvalid&&bready -> IDLE; awready=1 in the following cycle (one-cycle bubble minimum).
REQ-029 Latency: bvalid asserts cycle after final W handshake; AW-to-first-wready one cycle.
REQ-030 wvalid in IDLE or RESP ignored (wready=0); no 4KB-boundary checking.
REQ-031 Memory array not reset; dbg_rdata reflects writes the cycle after the write edge.

Reset
REQ-032 aresetn low: asynchronously to IDLE, awready=1, wready=0, bvalid=0, bresp=00, counter and error flags 0.
REQ-033 Reset mid-burst: burst abandoned, no B response, already-written beats retained.
REQ-034 awready=1 first rising edge with aresetn high.

Verification
REQ-035 INCR awaddr=0x10, awlen=3, awsize=2, wdata 0xA0..0xA3, wstrb=F -> words 4..7 = 0xA0..0xA3, bresp=00, bvalid one cycle after 4th beat.
REQ-036 WRAP awaddr=0x38, awlen=3, awsize=2 -> writes at words 14,15,12,13, bresp=00.
REQ-037 INCR awlen=3, wlast=1 on beat 2 -> beats 0..1 written, FSM to RESP, bresp=10.
REQ-038 MEM_DEPTH=256, awaddr=0x3FC, awlen=1, INCR size 2 -> word 255 written, beat 2 dropped, bresp=11.
REQ-039 awburst=11, awlen=0 -> beat accepted, memory unchanged, bresp=10; bready held low 5 cycles -> bvalid/bresp stable.
REQ-040 aresetn low after 2 of 4 beats -> awready=1, bvalid=0 asynchronously; beats 0..1 in memory; next burst completes OKAY.
